// File: rtl/vend_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vend_pkg: state encoding and coin/credit constants for vending_fsm |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_t;

  localparam logic [5:0] COIN_SMALL = 6'd1;
  localparam logic [5:0] COIN_LARGE = 6'd5;
  localparam logic [5:0] CREDIT_MAX = 6'd63;

endpackage
`default_nettype wire

// File: rtl/credit_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | credit_adder: 6-bit unsigned add with carry-out                  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module credit_adder (
  input  logic [5:0] i_a,
  input  logic [5:0] i_b,
  output logic [5:0] o_sum,
  output logic       o_carry
);

  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule
`default_nettype wire

// File: rtl/vending_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vending_fsm: coin credit, purchase and change-return controller  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module vending_fsm
  import vend_pkg::*;
#(
  parameter logic [5:0] PRICE = 6'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic       coin_type,
  input  logic       select,
  input  logic       cancel,
  output logic [5:0] credit,
  output logic       coin_reject,
  output logic       dispense,
  output logic       change_valid,
  output logic       change_type,
  output logic       busy
);

  state_t     r_state;
  logic [5:0] r_credit;
  logic       r_coin_reject;
  logic       r_dispense;
  logic       r_change_valid;
  logic       r_change_type;
  logic       r_busy;

  logic [5:0] w_coin_val;
  logic [5:0] w_sum;
  logic       w_carry;
  logic       w_overflow;
  logic       w_can_buy;

  assign w_coin_val = coin_type ? COIN_LARGE : COIN_SMALL;
  assign w_can_buy  = (r_credit >= PRICE);

  credit_adder u_credit_adder (
    .i_a     (r_credit),
    .i_b     (w_coin_val),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // 7-bit view of the sum so a full-scale credit of 63 is still accepted
  assign w_overflow = ({w_carry, w_sum} > {1'b0, CREDIT_MAX});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_credit       <= 6'd0;
      r_coin_reject  <= 1'b0;
      r_dispense     <= 1'b0;
      r_change_valid <= 1'b0;
      r_change_type  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_coin_reject  <= 1'b0;
      r_dispense     <= 1'b0;
      r_change_valid <= 1'b0;
      r_change_type  <= 1'b0;
      case (r_state)
        ST_IDLE, ST_CREDIT: begin
          // A command that is ignored does not steal the coin's slot
          if (cancel && (r_state == ST_CREDIT)) begin
            r_state       <= ST_CHANGE;
            r_busy        <= 1'b1;
            r_coin_reject <= coin_valid;
          end else if (select && w_can_buy) begin
            r_state       <= ST_DISPENSE;
            r_credit      <= r_credit - PRICE;
            r_dispense    <= 1'b1;
            r_busy        <= 1'b1;
            r_coin_reject <= coin_valid;
          end else if (coin_valid) begin
            if (w_overflow) begin
              r_coin_reject <= 1'b1;
            end else begin
              r_credit <= w_sum;
              r_state  <= ST_CREDIT;
            end
          end
        end
        ST_DISPENSE: begin
          r_coin_reject <= coin_valid;
          if (r_credit != 6'd0) begin
            r_state <= ST_CHANGE;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_CHANGE: begin
          r_coin_reject <= coin_valid;
          if (r_credit == 6'd0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_credit >= COIN_LARGE) begin
            r_change_valid <= 1'b1;
            r_change_type  <= 1'b1;
            r_credit       <= r_credit - COIN_LARGE;
          end else begin
            r_change_valid <= 1'b1;
            r_change_type  <= 1'b0;
            r_credit       <= r_credit - COIN_SMALL;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign credit       = r_credit;
  assign coin_reject  = r_coin_reject;
  assign dispense     = r_dispense;
  assign change_valid = r_change_valid;
  assign change_type  = r_change_type;
  assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vending_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_vending_fsm: directed self-checking bench for vending_fsm     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_vending_fsm;

  logic       clk;
  logic       rst;
  logic       coin_valid;
  logic       coin_type;
  logic       select;
  logic       cancel;
  logic [5:0] credit;
  logic       coin_reject;
  logic       dispense;
  logic       change_valid;
  logic       change_type;
  logic       busy;

  int checks = 0;
  int errors = 0;

  vending_fsm #(.PRICE(6'd7)) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .select       (select),
    .cancel       (cancel),
    .credit       (credit),
    .coin_reject  (coin_reject),
    .dispense     (dispense),
    .change_valid (change_valid),
    .change_type  (change_type),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare every output; change_type only matters while change_valid is expected
  task automatic outs(input string tag, input logic [5:0] e_cr, input logic e_busy,
                      input logic e_disp, input logic e_rej, input logic e_cv, input logic e_ct);
    chk({tag, ".credit"},       {2'b00, credit},       {2'b00, e_cr});
    chk({tag, ".busy"},         {7'd0, busy},          {7'd0, e_busy});
    chk({tag, ".dispense"},     {7'd0, dispense},      {7'd0, e_disp});
    chk({tag, ".coin_reject"},  {7'd0, coin_reject},   {7'd0, e_rej});
    chk({tag, ".change_valid"}, {7'd0, change_valid},  {7'd0, e_cv});
    if (e_cv) chk({tag, ".change_type"}, {7'd0, change_type}, {7'd0, e_ct});
  endtask

  // One clock with the given one-cycle pulses; outputs are sampled 1ns after the edge
  task automatic cyc(input logic cv, input logic ct, input logic sel, input logic can);
    coin_valid = cv;
    coin_type  = ct;
    select     = sel;
    cancel     = can;
    @(posedge clk);
    #1;
    coin_valid = 1'b0;
    coin_type  = 1'b0;
    select     = 1'b0;
    cancel     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; coin_valid = 1'b0; coin_type = 1'b0; select = 1'b0; cancel = 1'b0;
    @(posedge clk); #1;
    do_reset();
    outs("reset", 6'd0, 0, 0, 0, 0, 0);

    // Two large coins, buy, three small coins back
    cyc(1, 1, 0, 0); outs("s31.coin5a", 6'd5, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0); outs("s31.coin5b", 6'd10, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0); outs("s31.select", 6'd3, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0); outs("s31.disp_end", 6'd3, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0); outs("s31.chg1", 6'd2, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0); outs("s31.chg2", 6'd1, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0); outs("s31.chg3", 6'd0, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0); outs("s31.idle", 6'd0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1); outs("cancel_in_idle", 6'd0, 0, 0, 0, 0, 0);

    // Insufficient credit, then refund
    cyc(1, 0, 0, 0); outs("s32.coin1", 6'd1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0); outs("s32.coin5", 6'd6, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0); outs("s32.select_low", 6'd6, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1); outs("s32.cancel", 6'd6, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0); outs("s32.chg1", 6'd1, 1, 0, 0, 1, 1);
    cyc(0, 0, 0, 0); outs("s32.chg2", 6'd0, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0); outs("s32.idle", 6'd0, 0, 0, 0, 0, 0);

    // Overflow boundary near 63
    for (int i = 0; i < 12; i++) cyc(1, 1, 0, 0);
    outs("s33.credit60", 6'd60, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0); outs("s33.reject5", 6'd60, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0); outs("s33.coin1", 6'd61, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0); outs("s33.reject5b", 6'd61, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0); outs("s33.to62", 6'd62, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0); outs("s33.to63", 6'd63, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0); outs("s33.reject1_at63", 6'd63, 0, 0, 1, 0, 0);
    do_reset();
    outs("s33.reset", 6'd0, 0, 0, 0, 0, 0);

    // Exact price with a competing coin
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    outs("s34.credit7", 6'd7, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0); outs("s34.select_coin", 6'd0, 1, 1, 1, 0, 0);
    cyc(0, 0, 0, 0); outs("s34.idle", 6'd0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0); outs("s34.no_change", 6'd0, 0, 0, 0, 0, 0);

    // Reset aborts change return
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
    outs("s35.credit20", 6'd20, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0); outs("s35.select", 6'd13, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0); outs("s35.coin_in_disp", 6'd13, 1, 0, 1, 0, 0);
    coin_valid = 1'b1; coin_type = 1'b1;
    do_reset();
    coin_valid = 1'b0; coin_type = 1'b0;
    outs("s35.rst", 6'd0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0); outs("s35.after_rst", 6'd0, 0, 0, 0, 0, 0);
    end

    // Cancel beats select; commands and coins refused during change
    cyc(1, 1, 0, 0); for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    outs("s36.credit9", 6'd9, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1); outs("s36.cancel_select", 6'd9, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0); outs("s36.chg5_coin", 6'd4, 1, 0, 1, 1, 1);
    cyc(0, 0, 1, 1); outs("s36.chg1a", 6'd3, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0); outs("s36.chg1b", 6'd2, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0); outs("s36.chg1c", 6'd1, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0); outs("s36.chg1d", 6'd0, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0); outs("s36.idle", 6'd0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vending_fsm.md
VENDING_FSM -- requirements
Module: vending_fsm

Interface
REQ-001 SHALL have parameter PRICE, default 6'd7, product price in money units (1..63).
REQ-002 SHALL have port clk  input  1  rising-edge clock, all state changes on this edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port coin_valid  input  1  one-cycle pulse, a coin was inserted.
REQ-005 SHALL have port coin_type  input  1  0 = 1-unit coin, 1 = 5-unit coin; sampled with coin_valid.
REQ-006 SHALL have port select  input  1  one-cycle pulse, purchase request.
REQ-007 SHALL have port cancel  input  1  one-cycle pulse, refund request.
REQ-008 SHALL have port credit  output  6  current credit in units, registered.
REQ-009 SHALL have port coin_reject  output  1  one-cycle pulse, inserted coin not accepted.
REQ-010 SHALL have port dispense  output  1  one-cycle pulse, release product.
REQ-011 SHALL have port change_valid  output  1  one-cycle pulse per returned coin.
REQ-012 SHALL have port change_type  output  1  coin returned with change_valid: 0 = 1 unit, 1 = 5 units.
REQ-013 SHALL have port busy  output  1  high in DISPENSE and CHANGE.

Function
REQ-014 SHALL implement states IDLE (credit = 0), CREDIT (credit > 0), DISPENSE and CHANGE.
REQ-015 In IDLE/CREDIT, an accepted coin SHALL add 1 or 5 to credit, visible on credit the next cycle, and the state SHALL become CREDIT.
REQ-016 A coin whose addition would exceed 63 SHALL be rejected: credit unchanged, coin_reject high the next cycle.
REQ-017 Coins arriving in DISPENSE or CHANGE SHALL be rejected with coin_reject; credit unchanged.
REQ-018 Same-cycle priority SHALL be cancel > select > coin; a coin that loses priority SHALL be rejected.
REQ-019 select with credit >= PRICE SHALL move to DISPENSE next cycle, with dispense high exactly that one cycle and credit = credit - PRICE.
REQ-020 select with credit < PRICE SHALL be ignored: no state or credit change.
REQ-021 DISPENSE SHALL last one cycle, then go to CHANGE if the remaining credit > 0, else to IDLE.
REQ-022 cancel in CREDIT SHALL go to CHANGE next cycle; cancel in IDLE, DISPENSE or CHANGE SHALL be ignored.
REQ-023 Each CHANGE cycle SHALL pulse change_valid once, using change_type = 1 and credit -= 5 when credit >= 5, else change_type = 0 and credit -= 1.
REQ-024 CHANGE SHALL go to IDLE in the cycle after credit reaches 0; select and cancel SHALL be ignored in CHANGE.
REQ-025 All outputs SHALL be registered; dispense, change_valid and coin_reject SHALL never be high two cycles in a row for a single event.
REQ-026 All arithmetic SHALL be 6-bit unsigned, with no wrap-around permitted.

Reset
REQ-027 rst SHALL force IDLE, credit = 0 and all pulse outputs and busy = 0 on the next edge, overriding any input.
REQ-028 rst mid-DISPENSE or mid-CHANGE SHALL abort the operation with no further dispense or change pulses.

Structure
REQ-029 Package vend_pkg SHALL hold the state enum and the constants COIN_SMALL = 6'd1, COIN_LARGE = 6'd5 and CREDIT_MAX = 6'd63.
REQ-030 A single sub-module credit_adder (6-bit add with carry-out, used for the overflow check) SHALL be instantiated; subtraction stays inline.

Verification
REQ-031 Scenario: rst, then 5, 5 coins -> credit 5, then 10; select -> dispense pulse, credit 3; then change_type 0, 0, 0 on three consecutive cycles; IDLE.
REQ-032 Scenario: coins 1, 5 (credit 6), select -> no dispense, credit 6; cancel -> change_type 1 then 0; credit 0; IDLE.
REQ-033 Scenario: credit 60, 5-coin -> coin_reject, credit 60; then 1-coin -> credit 61.
REQ-034 Scenario: credit 7, with select and coin_valid in the same cycle -> dispense, coin_reject, credit 0, IDLE, no change pulses.
REQ-035 Scenario: credit 20, select -> DISPENSE, credit 13; rst during the first CHANGE cycle -> credit 0, IDLE, no further change_valid.
REQ-036 Scenario: cancel and select together at credit 9 -> no dispense; change_type 1, then four 0s.
